load_store_unit: RTL and testbench

Sits between the execute stage and the word-addressed data memory of the RISC-V core. Takes one byte-addressed load or store request at a time and performs alignment checking and range checking. It converts the byte address to a word index and drives the memory's read/write enables. Sub-word stores are done as read-modify-write, because the memory has no byte enables. Load data is extracted, sign- or zero-extended, and returned on a single-cycle response.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-addressed data memory.
// Checks alignment, size and range. Converts the byte address to a word index. Does
// sub-word stores as read-modify-write, because the memory has no byte enables. Returns
// sign- or zero-extended load data on a one-cycle response.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake; ready only while idle
//   req_we, req_size        1 = store; size 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned            zero-extend sub-word loads when set
//   req_addr, req_wdata     byte address, right-justified store data
//   resp_valid/err/rdata    one-cycle response; err and rdata hold between responses
//   mem_addr                word index of the registered request
//   mem_rd_en, mem_rd_data  combinational-read port
//   mem_wr_en, mem_wr_data  write port, written at the edge ending the cycle
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StRmwRd,
        StRmwWr,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_fire;
    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_fire = req_valid && (state_q == StIdle);

    // Any of these kills the request before it ever touches memory.
    assign req_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = {2'b00, addr_q[31:2]};

    // Lane extraction and extension of the word read during StLoad.
    always_comb begin
        lane_byte = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
        lane_half = mem_rd_data[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_data = uns_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_data = mem_rd_data;
        endcase
    end

    // Replace only the addressed lane of the word captured in StRmwRd.
    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 32'h0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_we) begin
                        state_d = StLoad;
                    end else if (req_size == 2'b10) begin
                        state_d = StStore;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                mem_rd_en = 1'b1;
                state_d   = StResp;
            end
            StStore: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = wdata_q;
                state_d     = StResp;
            end
            StRmwRd: begin
                mem_rd_en = 1'b1;
                state_d   = StRmwWr;
            end
            StRmwWr: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = merged;
                state_d     = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                // Errors go straight to StResp, so the response fields load here.
                if (req_err) begin
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= 32'h0;
                end
            end
            if (state_q == StLoad) begin
                resp_rdata_q <= load_data;
                resp_err_q   <= 1'b0;
            end
            if (state_q == StStore || state_q == StRmwWr) begin
                resp_rdata_q <= 32'h0;
                resp_err_q   <= 1'b0;
            end
            if (state_q == StRmwRd) begin
                merge_q <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, a behavioural reference model with its own
// memory image, a per-cycle compare process, and literal expectations on key results.
module tb_load_store_unit;

    localparam int DEPTH = 32;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;

    load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: combinational read, write at the rising edge.
    logic        mem_clear;
    logic [31:0] mem [DEPTH];
    assign mem_rd_data = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (mem_wr_en) begin
            mem[mem_addr[4:0]] <= mem_wr_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, owned by the compare process.
    logic [31:0] model_mem [DEPTH];
    bit          busy;
    int          k;
    int          lat;
    bit          e_err;
    bit          e_load;
    bit          e_word_st;
    logic [31:0] e_rdata;
    logic [31:0] e_word;
    logic [31:0] e_idx;
    logic [31:0] m_w;
    logic [31:0] m_v;
    int          m_sh;
    logic [31:0] held_rdata;
    bit          held_err;
    bit          x_rd;
    bit          x_wr;
    bit          x_valid;
    bit          x_ready;
    logic [31:0] x_wd;

    // Predict a whole transaction from the request fields and the model memory image.
    task automatic model_accept();
        e_idx     = req_addr >> 2;
        m_sh      = int'(req_addr & 32'd3) * 8;
        e_err     = (req_size == 2'd3) || (req_size == 2'd1 && (req_addr % 2) != 0)
                    || (req_size == 2'd2 && (req_addr % 4) != 0) || (e_idx >= DEPTH);
        e_load    = !req_we;
        e_word_st = req_we && (req_size == 2'd2);
        lat       = e_err ? 1 : ((e_load || e_word_st) ? 2 : 3);
        e_rdata   = 32'h0;
        e_word    = 32'h0;
        if (!e_err) begin
            m_w = model_mem[e_idx[4:0]];
            if (e_load) begin
                if (req_size == 2'd0) begin
                    m_v = (m_w >> m_sh) & 32'hFF;
                    if (!req_unsigned && m_v >= 32'h80) m_v = m_v | 32'hFFFFFF00;
                end else if (req_size == 2'd1) begin
                    m_v = (m_w >> m_sh) & 32'hFFFF;
                    if (!req_unsigned && m_v >= 32'h8000) m_v = m_v | 32'hFFFF0000;
                end else begin
                    m_v = m_w;
                end
                e_rdata = m_v;
            end else if (req_size == 2'd2) begin
                e_word = req_wdata;
            end else if (req_size == 2'd0) begin
                e_word = (m_w & ~(32'hFF << m_sh)) | ((req_wdata & 32'hFF) << m_sh);
            end else begin
                e_word = (m_w & ~(32'hFFFF << m_sh)) | ((req_wdata & 32'hFFFF) << m_sh);
            end
        end
    endtask

    // Compare process: every falling edge, check all outputs against the model's schedule.
    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        end
        if (reset) begin
            busy       = 1'b0;
            held_rdata = 32'h0;
            held_err   = 1'b0;
            check("rst_req_ready", {31'h0, req_ready}, 32'd1);
            check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
            check("rst_resp_err", {31'h0, resp_err}, 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'h0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_mem_rd_en", {31'h0, mem_rd_en}, 32'd0);
            check("rst_mem_wr_en", {31'h0, mem_wr_en}, 32'd0);
            check("rst_mem_wr_data", mem_wr_data, 32'h0);
        end else begin
            x_rd = 1'b0; x_wr = 1'b0; x_valid = 1'b0; x_ready = 1'b1; x_wd = 32'h0;
            if (busy) begin
                k++;
                x_ready = 1'b0;
                x_valid = (k == lat);
                if (!e_err) begin
                    x_rd = (k == 1) && (e_load || !e_word_st);
                    x_wr = (!e_load && e_word_st && k == 1) || (!e_load && !e_word_st && k == 2);
                end
                if (x_wr) x_wd = e_word;
                if (x_valid) begin
                    held_rdata = e_rdata;
                    held_err   = e_err;
                end
            end
            check("req_ready", {31'h0, req_ready}, {31'h0, x_ready});
            check("resp_valid", {31'h0, resp_valid}, {31'h0, x_valid});
            check("mem_rd_en", {31'h0, mem_rd_en}, {31'h0, x_rd});
            check("mem_wr_en", {31'h0, mem_wr_en}, {31'h0, x_wr});
            check("mem_wr_data", mem_wr_data, x_wd);
            check("resp_err", {31'h0, resp_err}, {31'h0, held_err});
            check("resp_rdata", resp_rdata, held_rdata);
            if (x_rd || x_wr) check("mem_addr", mem_addr, e_idx);
            if (busy && x_valid) begin
                if (!e_err && !e_load) begin
                    check("mem_word", mem[e_idx[4:0]], e_word);
                    model_mem[e_idx[4:0]] = e_word;
                end
                busy = 1'b0;
            end
            if (req_valid && req_ready) begin
                model_accept();
                busy = 1'b1;
                k    = 0;
            end
        end
    end

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    // Present a request while idle; returns one cycle after the accept edge (in C1).
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", {31'h0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Latency counts falling edges from the accept edge: C1 is 1.
    task automatic wait_resp();
        int n;
        n = 0;
        last_lat = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (resp_valid) begin
                last_lat   = n;
                last_err   = resp_err;
                last_rdata = resp_rdata;
                break;
            end
        end
        if (last_lat == 0) check("resp_timeout", {31'h0, resp_valid}, 32'd1);
    endtask

    task automatic op(input string name, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rdata);
        send(we, size, uns, addr, wdata);
        wait_resp();
        check({name, "_lat"}, last_lat, exp_lat);
        check({name, "_err"}, {31'h0, last_err}, {31'h0, exp_err});
        check({name, "_rdata"}, last_rdata, exp_rdata);
    endtask

    initial begin
        reset = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        reset = 1'b0;

        // Word store and load back.
        op("sw_0c", 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        check("mem3_sw", mem[3], 32'hDEADBEEF);
        op("lw_0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 2, 1'b0, 32'hDEADBEEF);

        // Sub-word stores by read-modify-write.
        op("sw_init3", 1'b1, 2'b10, 1'b0, 32'h0C, 32'h11223344, 2, 1'b0, 32'h0);
        op("sb_0d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFFFFA5, 3, 1'b0, 32'h0);
        check("mem3_sb", mem[3], 32'h1122A544);
        op("sh_0e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234BEEF, 3, 1'b0, 32'h0);
        check("mem3_sh", mem[3], 32'hBEEFA544);

        // Load extension.
        op("sw_init4", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 2, 1'b0, 32'h0);
        op("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFF88);
        op("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'h00000088);
        op("lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFAABB);
        op("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'h0000AABB);
        op("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'hFFFF8899);
        op("lbu_0d", 1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, 2, 1'b0, 32'h000000A5);
        op("lw_uns", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'h8899AABB);
        op("lb_10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hFFFFFFBB);

        // Reset while idle clears the held response immediately.
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("idle_rst_rdata", resp_rdata, 32'h0);
        check("idle_rst_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Error cases.
        op("err_lw_0e", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 1, 1'b1, 32'h0);
        op("err_sh_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 1, 1'b1, 32'h0);
        op("err_size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h0);
        op("err_sw_80", 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, 1, 1'b1, 32'h0);
        op("ok_after_err", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 2, 1'b0, 32'h0);

        // Reset during RMW_RD: no write, no response.
        send(1'b1, 2'b00, 1'b0, 32'h0D, 32'h00000077);
        reset = 1'b1;
        #1;
        check("rmw_rst_rd_en", {31'h0, mem_rd_en}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rmw_rst_mem3", mem[3], 32'hBEEFA544);
        check("rmw_rst_ready", {31'h0, req_ready}, 32'd1);
        op("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 2, 1'b0, 32'hBEEFA544);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
